// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush and forwarding control for the 5-stage RV32I
// pipeline, with post-reset init flush and timed data-memory wait sequencing.
// Optional build macro: HAZARD_PERF_CNT_EN enables the stall/flush perf counters.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// S_INIT     | post-reset flush: hold PC, bubble ID and EX for INIT_CYCLES clocks
// S_RUN      | normal issue: branch flush, load-use stall, memory freeze entry
// S_MEM_WAIT | data memory busy: whole pipe frozen until ready, drop or timeout
module pipeline_hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 200,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_idx_d,
  input  logic [4:0]  rs2_idx_d,
  input  logic [4:0]  rs1_idx_e,
  input  logic [4:0]  rs2_idx_e,
  input  logic [4:0]  rd_idx_e,
  input  logic        MemRead_e,
  input  logic        pc_src_e,
  input  logic        RegWrite_m,
  input  logic [4:0]  rd_idx_m,
  input  logic        RegWrite_w,
  input  logic [4:0]  rd_idx_w,
  input  logic        dmem_req_m,
  input  logic        dmem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        mem_err,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MEM_WAIT} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_init_cnt;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic [TIMEOUT_W-1:0] w_wait_nxt;
  logic                 w_mem_stall;
  logic                 w_load_use;
  logic                 w_timeout;

  assign w_mem_stall = dmem_req_m && !dmem_ready;
  assign w_load_use  = MemRead_e && (rd_idx_e != 5'd0) &&
                       ((rd_idx_e == rs1_idx_d) || (rd_idx_e == rs2_idx_d));
  assign w_timeout   = (r_wait_cnt >= TIMEOUT_W'(TIMEOUT));

  // EX operand forwarding, MEM result takes priority over WB
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWrite_m && (rd_idx_m != 5'd0) && (rd_idx_m == rs1_idx_e))
      ForwardAE = 2'b10;
    else if (RegWrite_w && (rd_idx_w != 5'd0) && (rd_idx_w == rs1_idx_e))
      ForwardAE = 2'b01;
    if (RegWrite_m && (rd_idx_m != 5'd0) && (rd_idx_m == rs2_idx_e))
      ForwardBE = 2'b10;
    else if (RegWrite_w && (rd_idx_w != 5'd0) && (rd_idx_w == rs2_idx_e))
      ForwardBE = 2'b01;
  end

  // Stall/flush decode and next-state selection
  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushW      = 1'b0;
    mem_err     = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      S_INIT: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (r_init_cnt == 4'd0) w_state_nxt = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        if (r_state == S_MEM_WAIT && !dmem_ready && w_timeout) begin
          // abandoned access: release everything, kill the stale writeback
          mem_err     = 1'b1;
          FlushW      = 1'b1;
          w_state_nxt = S_RUN;
        end else if (w_mem_stall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
          FlushW = 1'b1;
          if (r_state == S_RUN) begin
            w_state_nxt = S_MEM_WAIT;
            w_wait_nxt  = TIMEOUT_W'(1);
          end else begin
            w_wait_nxt  = r_wait_cnt + TIMEOUT_W'(1);
          end
        end else begin
          // ready, request dropped, or no access: normal issue rules
          w_state_nxt = S_RUN;
          if (pc_src_e) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (w_load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // State, init countdown and memory wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_INIT;
      r_init_cnt <= 4'(INIT_CYCLES - 1);
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (r_state == S_INIT && r_init_cnt != 4'd0)
        r_init_cnt <= r_init_cnt - 4'd1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  // Performance counters, init flush cycles are not counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall_cnt <= 32'd0;
      r_perf_flush_cnt <= 32'd0;
    end else if (r_state != S_INIT) begin
      if (StallF) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (FlushE) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_flush_cnt = r_perf_flush_cnt;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int INIT_CYCLES = 2;
  localparam int TIMEOUT     = 5;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_idx_d, rs2_idx_d, rs1_idx_e, rs2_idx_e, rd_idx_e, rd_idx_m, rd_idx_w;
  logic MemRead_e, pc_src_e, RegWrite_m, RegWrite_w, dmem_req_m, dmem_ready;
  logic StallF, StallD, FlushD, FlushE, StallE, StallM, FlushW, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  pipeline_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .TIMEOUT(TIMEOUT), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset),
    .rs1_idx_d(rs1_idx_d), .rs2_idx_d(rs2_idx_d),
    .rs1_idx_e(rs1_idx_e), .rs2_idx_e(rs2_idx_e), .rd_idx_e(rd_idx_e),
    .MemRead_e(MemRead_e), .pc_src_e(pc_src_e),
    .RegWrite_m(RegWrite_m), .rd_idx_m(rd_idx_m),
    .RegWrite_w(RegWrite_w), .rd_idx_w(rd_idx_w),
    .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallE(StallE), .StallM(StallM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // model state: clocks of init flush left, whether a memory access is pending, its age
  int           m_init_left = INIT_CYCLES;
  bit           m_waiting   = 0;
  int           m_age       = 0;
  logic [31:0]  m_pstall    = 0;
  logic [31:0]  m_pflush    = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWrite_m && rd_idx_m != 0 && rd_idx_m == rs) return 2'b10;
    if (RegWrite_w && rd_idx_w != 0 && rd_idx_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Compute what every output must be this cycle, compare, then advance the model
  task automatic settle_check();
    bit sf, sd, fd, fe, se, sm, fw, er;
    bit in_init, issue;
    #1;
    n_vec++;
    {sf, sd, fd, fe, se, sm, fw, er} = '0;
    issue = 0;
    in_init = (!reset) || (m_init_left > 0);
    if (in_init) begin
      sf = 1; fd = 1; fe = 1;
    end else if (m_waiting && !dmem_ready && m_age >= TIMEOUT) begin
      er = 1; fw = 1;
    end else if (dmem_req_m && !dmem_ready) begin
      {sf, sd, se, sm, fw} = 5'b11111;
    end else begin
      issue = 1;
    end
    if (issue) begin
      if (pc_src_e) begin
        fd = 1; fe = 1;
      end else if (MemRead_e && rd_idx_e != 0 && (rd_idx_e == rs1_idx_d || rd_idx_e == rs2_idx_d)) begin
        sf = 1; sd = 1; fe = 1;
      end
    end
    cmp("StallF", 32'(StallF), 32'(sf));
    cmp("StallD", 32'(StallD), 32'(sd));
    cmp("FlushD", 32'(FlushD), 32'(fd));
    cmp("FlushE", 32'(FlushE), 32'(fe));
    cmp("StallE", 32'(StallE), 32'(se));
    cmp("StallM", 32'(StallM), 32'(sm));
    cmp("FlushW", 32'(FlushW), 32'(fw));
    cmp("mem_err", 32'(mem_err), 32'(er));
    cmp("ForwardAE", 32'(ForwardAE), 32'(fwd(rs1_idx_e)));
    cmp("ForwardBE", 32'(ForwardBE), 32'(fwd(rs2_idx_e)));
`ifdef HAZARD_PERF_CNT_EN
    cmp("perf_stall_cnt", perf_stall_cnt, m_pstall);
    cmp("perf_flush_cnt", perf_flush_cnt, m_pflush);
`else
    cmp("perf_stall_cnt", perf_stall_cnt, 32'd0);
    cmp("perf_flush_cnt", perf_flush_cnt, 32'd0);
`endif
    // advance to the state seen after the coming clock edge
    if (!reset) begin
      m_init_left = INIT_CYCLES; m_waiting = 0; m_age = 0; m_pstall = 0; m_pflush = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (sf) m_pstall++;
      if (fe) m_pflush++;
      if (sm) begin
        m_age     = m_waiting ? m_age + 1 : 1;
        m_waiting = 1;
      end else begin
        m_waiting = 0;
      end
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {rs1_idx_d, rs2_idx_d, rs1_idx_e, rs2_idx_e, rd_idx_e, rd_idx_m, rd_idx_w} = '0;
    {MemRead_e, pc_src_e, RegWrite_m, RegWrite_w, dmem_req_m, dmem_ready} = '0;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    cmp(nm, act, exp);
  endtask

  int ready_pct;

  initial begin
    reset = 1'b0;
    idle();
    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      settle_check();
      lit("rst_StallF", 32'(StallF), 1);
      lit("rst_mem_err", 32'(mem_err), 0);
      next_cyc();
    end
    reset = 1'b1;
    // exactly INIT_CYCLES cycles of init flush after release
    for (int i = 0; i < INIT_CYCLES; i++) begin
      settle_check();
      lit("init_StallF", 32'(StallF), 1);
      lit("init_FlushE", 32'(FlushE), 1);
      next_cyc();
    end
    settle_check();
    lit("run_StallF", 32'(StallF), 0);
    lit("run_FlushD", 32'(FlushD), 0);
    next_cyc();

    // load-use hazard and its rd=x0 exemption
    MemRead_e = 1; rd_idx_e = 5; rs2_idx_d = 5;
    settle_check();
    lit("lu_stall", {29'd0, StallF, StallD, FlushE}, 32'b111);
    next_cyc();
    rd_idx_e = 0; rs2_idx_d = 0;
    settle_check();
    lit("lu_x0", {29'd0, StallF, StallD, FlushE}, 32'b000);
    next_cyc();
    idle();

    // forwarding priority
    RegWrite_m = 1; rd_idx_m = 3; RegWrite_w = 1; rd_idx_w = 3; rs1_idx_e = 3;
    settle_check();
    lit("fwd_mem", 32'(ForwardAE), 32'b10);
    next_cyc();
    RegWrite_m = 0;
    settle_check();
    lit("fwd_wb", 32'(ForwardAE), 32'b01);
    next_cyc();
    idle();

    // memory wait of 4 cycles with a branch resolving during the freeze
    dmem_req_m = 1;
    for (int i = 0; i < 4; i++) begin
      pc_src_e = (i >= 1);
      settle_check();
      lit("mw_StallM", 32'(StallM), 1);
      lit("mw_FlushD_masked", 32'(FlushD), 0);
      next_cyc();
    end
    dmem_ready = 1;
    settle_check();
    lit("mw_release", 32'(StallM), 0);
    lit("mw_branch_flush", 32'(FlushD), 1);
    next_cyc();
    idle();
    settle_check();
    lit("mw_back_run", 32'(StallF), 0);
    next_cyc();

    // timeout: TIMEOUT freeze cycles, then a single error cycle
    dmem_req_m = 1;
    for (int i = 0; i < TIMEOUT; i++) begin
      settle_check();
      lit("to_freeze", 32'(StallF), 1);
      next_cyc();
    end
    settle_check();
    lit("to_mem_err", 32'(mem_err), 1);
    lit("to_FlushW", 32'(FlushW), 1);
    lit("to_nostall", {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
    next_cyc();
    idle();
    settle_check();
    lit("to_after", 32'(mem_err), 0);
    next_cyc();

    // randomized traffic, two phases of memory responsiveness, rare resets
    for (int i = 0; i < 4000; i++) begin
      ready_pct = (i < 2000) ? 60 : 10;
      reset      = ($urandom_range(399) != 0);
      rs1_idx_d  = 5'($urandom_range(3));
      rs2_idx_d  = 5'($urandom_range(3));
      rs1_idx_e  = 5'($urandom_range(3));
      rs2_idx_e  = 5'($urandom_range(3));
      rd_idx_e   = 5'($urandom_range(3));
      rd_idx_m   = 5'($urandom_range(3));
      rd_idx_w   = 5'($urandom_range(3));
      MemRead_e  = 1'($urandom_range(1));
      pc_src_e   = ($urandom_range(99) < 15);
      RegWrite_m = 1'($urandom_range(1));
      RegWrite_w = 1'($urandom_range(1));
      dmem_req_m = ($urandom_range(99) < 40);
      dmem_ready = ($urandom_range(99) < ready_pct);
      settle_check();
      next_cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
